srl_cam_wr_gen: RTL and testbench
=================================

Name: srl_cam_wr_gen

Overview:
Write-data generator for the SRL-based CAM update path. It accepts one rule write (key, care-mask, target entry) per request over a valid/ready handshake. It then runs a 32-cycle shift sequence that drives the one-hot shift-enable and per-slice serial data into the SRL32 columns of the selected CAM entry. Each 5-bit key slice is expanded into a 32-bit match vector, one bit per SRL address. It sits directly upstream of the CAM SRL array, alongside the write counter/flag logic that sequences entry groups.

Parameters:
DATA_WIDTH, 40, key width in bits; must be a multiple of 5.
ADDR_WIDTH, 3, entry address width; number of entries NUM_ENTRIES = 2**ADDR_WIDTH.
NUM_SLICES (localparam), DATA_WIDTH/5, number of SRL32 columns per entry.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
s_valid  in  1  write request valid
s_ready  out  1  block can accept a request
s_data  in  DATA_WIDTH  rule key
s_mask  in  DATA_WIDTH  care mask; 1 = bit compared, 0 = don't care
s_addr  in  ADDR_WIDTH  target CAM entry
s_clear  in  1  erase entry; all shifted bits are 0
srl_ce  out  NUM_ENTRIES  one-hot SRL shift enable
srl_din  out  NUM_SLICES  serial shift data, bit j feeds slice j
busy  out  1  shift sequence in progress
done  out  1  one-cycle pulse when the entry write completes

Behaviour:
- Reset is synchronous, active-high; clock is clk.
- Reset values: state=IDLE, s_ready=1, srl_ce=0, srl_din=0, busy=0, done=0, k=0.
- Handshake: a request transfers when s_valid & s_ready are high at a rising edge. Call that edge T.
  - On transfer, s_data, s_mask, s_addr and s_clear are latched.
  - Inputs are ignored when no transfer occurs.
- States:
  - IDLE: s_ready=1. On transfer, go to SHIFT with the 5-bit shift index k=31.
  - SHIFT: s_ready=0. Decrement k each cycle. When k==0, go to DONE.
  - DONE: s_ready=1, done=1 for this single cycle. On transfer, go to SHIFT with k=31; otherwise go to IDLE.
- All outputs are registered.
- Cycles T+1..T+32: srl_ce = one-hot(latched addr), busy=1, k runs 31 down to 0.
  - At cycle T+n, k = 32-n.
  - srl_din[j] = ~clear & (((k ^ data[5j+4:5j]) & mask[5j+4:5j]) == 0).
  - k=31 is shifted first, so after 32 shifts SRL address k holds the match bit for key value k.
- Cycle T+33: done=1, srl_ce=0, srl_din=0, busy=0.
- Back-to-back throughput: one entry every 33 cycles. A transfer in DONE starts SHIFT at T+34 with no idle gap.
- Outside SHIFT, srl_ce and srl_din are 0.
- Reset mid-SHIFT: srl_ce=0 from the next cycle and no done pulse. The partially written entry is undefined and must be rewritten.
- A fully masked slice (mask slice = 0) produces srl_din[j]=1 for all 32 cycles, unless clear is set.

Optional Feature:
Macro SRL_WR_QUEUE_EN.
- Defined: adds a one-entry pending register.
  - In SHIFT, s_ready = ~pend_valid, and a transfer in SHIFT fills the pending register.
  - In DONE, a valid pending entry is loaded, SHIFT restarts next cycle, and pend_valid clears. In the same DONE cycle s_ready=1 and a new transfer refills the pending register.
  - The pending register is cleared by reset.
- Not defined: no pending register; s_ready=0 throughout SHIFT as described above.

Test Plan:
- Exact match, first/last shift cycles: data=0, mask=all 1, addr=3, clear=0 -> srl_ce=8'b00001000 for T+1..T+32; srl_din=all 1 only at T+32 (k=0), all 0 at T+1..T+31; done=1 at T+33.
- Partial mask: slice0 data=5'b10101, mask=5'b11110 -> srl_din[0]=1 only at T+11 (k=21) and T+12 (k=20); other slices follow their own data.
- Don't-care and erase: mask=0, clear=0 -> srl_din all 1 for 32 cycles; same request with clear=1 -> srl_din all 0 while srl_ce is still asserted for 32 cycles.
- Back-to-back: s_valid held high with addr 1 then addr 6 -> ce=8'b00000010 on T+1..T+32, done at T+33, ce=8'b01000000 on T+34..T+65; s_ready=0 on T+1..T+32.
- Reset at T+10 -> srl_ce=0, busy=0, s_ready=1 from T+11; no done pulse; the next request runs a full 32 cycles.
- SRL_WR_QUEUE_EN: second request presented at T+5 -> accepted at T+5, s_ready=0 from T+6, second sequence ce on T+34..T+65, done at T+33 and T+66.

Source files
------------

// File: rtl/srl_cam_wr_gen.sv
// srl_cam_wr_gen: write-data generator for the SRL32-based CAM update path.
// It accepts one rule write (key, care mask, target entry, clear) over a valid/ready
// handshake. It then runs a 32-cycle shift sequence. Each cycle drives a one-hot
// entry shift enable and one serial match bit per 5-bit key slice.
// Optional feature macro: SRL_WR_QUEUE_EN adds a one-entry pending request register.
module srl_cam_wr_gen #(
   parameter int DATA_WIDTH = 40,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic [DATA_WIDTH-1:0]         s_data,
   input  logic [DATA_WIDTH-1:0]         s_mask,
   input  logic [ADDR_WIDTH-1:0]         s_addr,
   input  logic                          s_clear,
   output logic [(2**ADDR_WIDTH)-1:0]    srl_ce,
   output logic [(DATA_WIDTH/5)-1:0]     srl_din,
   output logic                          busy,
   output logic                          done
);

   localparam int NUM_SLICES  = DATA_WIDTH / 5;
   localparam int NUM_ENTRIES = 2 ** ADDR_WIDTH;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   // Match bit per slice for SRL address k: the slice key equals k on every cared bit.
   function automatic logic [NUM_SLICES-1:0] match_bits(
      input logic [4:0]            kv,
      input logic [DATA_WIDTH-1:0] d,
      input logic [DATA_WIDTH-1:0] m,
      input logic                  c
   );
      logic [NUM_SLICES-1:0] r;
      r = '0;
      for (int j = 0; j < NUM_SLICES; j++) begin
         r[j] = ~c & (((kv ^ d[5*j +: 5]) & m[5*j +: 5]) == 5'd0);
      end
      return r;
   endfunction

   state_t                  state, state_n;
   logic [4:0]              k, k_n;
   logic [ADDR_WIDTH-1:0]   addr_r, addr_n;
   logic [DATA_WIDTH-1:0]   data_r, data_n;
   logic [DATA_WIDTH-1:0]   mask_r, mask_n;
   logic                    clear_r, clear_n;
   logic                    xfer;
   logic                    ready_n;
   logic                    busy_n;
   logic                    done_n;
   logic [NUM_ENTRIES-1:0]  ce_n;
   logic [NUM_SLICES-1:0]   din_n;

`ifdef SRL_WR_QUEUE_EN
   logic                    pend_valid, pend_valid_n;
   logic [ADDR_WIDTH-1:0]   pend_addr, pend_addr_n;
   logic [DATA_WIDTH-1:0]   pend_data, pend_data_n;
   logic [DATA_WIDTH-1:0]   pend_mask, pend_mask_n;
   logic                    pend_clear, pend_clear_n;
`endif

   assign xfer = s_valid & s_ready;

   // Next-state, request latching and next-cycle output values (outputs are registered).
   always_comb begin
      state_n = state;
      k_n     = k;
      addr_n  = addr_r;
      data_n  = data_r;
      mask_n  = mask_r;
      clear_n = clear_r;
`ifdef SRL_WR_QUEUE_EN
      pend_valid_n = pend_valid;
      pend_addr_n  = pend_addr;
      pend_data_n  = pend_data;
      pend_mask_n  = pend_mask;
      pend_clear_n = pend_clear;
`endif
      case (state)
         IDLE: begin
            if (xfer) begin
               state_n = SHIFT;
               k_n     = 5'd31;
               addr_n  = s_addr;
               data_n  = s_data;
               mask_n  = s_mask;
               clear_n = s_clear;
            end
         end
         SHIFT: begin
            if (k == 5'd0) state_n = DONE;
            else           k_n     = k - 5'd1;
`ifdef SRL_WR_QUEUE_EN
            if (xfer) begin
               pend_valid_n = 1'b1;
               pend_addr_n  = s_addr;
               pend_data_n  = s_data;
               pend_mask_n  = s_mask;
               pend_clear_n = s_clear;
            end
`endif
         end
         DONE: begin
`ifdef SRL_WR_QUEUE_EN
            if (pend_valid) begin
               // Pending request goes first; a same-cycle transfer refills the slot.
               state_n      = SHIFT;
               k_n          = 5'd31;
               addr_n       = pend_addr;
               data_n       = pend_data;
               mask_n       = pend_mask;
               clear_n      = pend_clear;
               pend_valid_n = xfer;
               if (xfer) begin
                  pend_addr_n  = s_addr;
                  pend_data_n  = s_data;
                  pend_mask_n  = s_mask;
                  pend_clear_n = s_clear;
               end
            end else if (xfer) begin
`else
            if (xfer) begin
`endif
               state_n = SHIFT;
               k_n     = 5'd31;
               addr_n  = s_addr;
               data_n  = s_data;
               mask_n  = s_mask;
               clear_n = s_clear;
            end else begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase

      ce_n  = '0;
      din_n = '0;
      if (state_n == SHIFT) begin
         ce_n[addr_n] = 1'b1;
         din_n        = match_bits(k_n, data_n, mask_n, clear_n);
      end
      busy_n = (state_n == SHIFT);
      done_n = (state_n == DONE);
`ifdef SRL_WR_QUEUE_EN
      ready_n = (state_n != SHIFT) | ~pend_valid_n;
`else
      ready_n = (state_n != SHIFT);
`endif
   end

   // Control state and registered outputs, cleared by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         k       <= 5'd0;
         s_ready <= 1'b1;
         srl_ce  <= '0;
         srl_din <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_n;
         k       <= k_n;
         s_ready <= ready_n;
         srl_ce  <= ce_n;
         srl_din <= din_n;
         busy    <= busy_n;
         done    <= done_n;
      end
   end

   // Latched request fields; only consumed while shifting, so no reset needed.
   always_ff @(posedge clk) begin
      addr_r  <= addr_n;
      data_r  <= data_n;
      mask_r  <= mask_n;
      clear_r <= clear_n;
   end

`ifdef SRL_WR_QUEUE_EN
   // Pending-slot valid flag, cleared by reset.
   always_ff @(posedge clk) begin
      if (reset) pend_valid <= 1'b0;
      else       pend_valid <= pend_valid_n;
   end

   // Pending-slot request fields.
   always_ff @(posedge clk) begin
      pend_addr  <= pend_addr_n;
      pend_data  <= pend_data_n;
      pend_mask  <= pend_mask_n;
      pend_clear <= pend_clear_n;
   end
`endif

endmodule

// File: tb/tb_srl_cam_wr_gen.sv
// tb_srl_cam_wr_gen: directed plus randomized bench for srl_cam_wr_gen.
// Expected shift data comes from the match rule evaluated per key value.
module tb_srl_cam_wr_gen;

   localparam int DW = 40;
   localparam int AW = 3;
   localparam int NS = DW / 5;
   localparam int NE = 2 ** AW;
`ifdef SRL_WR_QUEUE_EN
   localparam bit QMODE = 1'b1;
`else
   localparam bit QMODE = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [DW-1:0] s_data = '0;
   logic [DW-1:0] s_mask = '0;
   logic [AW-1:0] s_addr = '0;
   logic          s_clear = 1'b0;
   logic [NE-1:0] srl_ce;
   logic [NS-1:0] srl_din;
   logic          busy;
   logic          done;

   int vectors = 0;
   int miscompares = 0;
   bit pend_exp = 1'b0;
   logic [DW-1:0] q_data, q_mask;
   logic [AW-1:0] q_addr;
   logic          q_clear;

   srl_cam_wr_gen #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset(reset),
      .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .s_mask(s_mask), .s_addr(s_addr), .s_clear(s_clear),
      .srl_ce(srl_ce), .srl_din(srl_din), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Reference: SRL address kval must hold 1 when the slice key equals kval on every cared bit.
   function automatic logic [NS-1:0] exp_din(input int kval, input logic [DW-1:0] d,
                                             input logic [DW-1:0] m, input logic c);
      logic [NS-1:0] r;
      int sd, sm;
      r = '0;
      for (int j = 0; j < NS; j++) begin
         sd = int'((d >> (5 * j)) & 40'd31);
         sm = int'((m >> (5 * j)) & 40'd31);
         r[j] = !c && ((kval & sm) == (sd & sm));
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_ce"}, 64'(srl_ce), 64'd0);
      chk({tag, "_din"}, 64'(srl_din), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_done"}, 64'(done), 64'd0);
      chk({tag, "_ready"}, 64'(s_ready), 64'd1);
   endtask

   // Present a request at the current negedge; returns at the negedge of cycle T+1.
   task automatic xfer(input logic [DW-1:0] d, input logic [DW-1:0] m,
                       input logic [AW-1:0] a, input logic c);
      s_valid = 1'b1; s_data = d; s_mask = m; s_addr = a; s_clear = c;
      chk("ready_at_xfer", 64'(s_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      s_valid = 1'b0;
      s_data = DW'({$urandom, $urandom});
      s_mask = DW'({$urandom, $urandom});
      s_addr = AW'($urandom);
      s_clear = 1'($urandom);
   endtask

   // Check shift cycles T+1..T+ncyc; optionally present the queued request during cycle q_at.
   task automatic check_shift(input logic [DW-1:0] d, input logic [DW-1:0] m,
                              input logic [AW-1:0] a, input logic c,
                              input int ncyc, input int q_at);
      for (int n = 1; n <= ncyc; n++) begin
         chk("shift_ce", 64'(srl_ce), 64'(1) << a);
         chk("shift_din", 64'(srl_din), 64'(exp_din(32 - n, d, m, c)));
         chk("shift_busy", 64'(busy), 64'd1);
         chk("shift_done", 64'(done), 64'd0);
         chk("shift_ready", 64'(s_ready), 64'(QMODE && !pend_exp));
         if (n == q_at) begin
            s_valid = 1'b1; s_data = q_data; s_mask = q_mask; s_addr = q_addr; s_clear = q_clear;
         end
         @(negedge clk);
         if (n == q_at) begin
            s_valid = 1'b0;
            pend_exp = 1'b1;
         end
      end
   endtask

   task automatic check_done();
      chk("done_pulse", 64'(done), 64'd1);
      chk("done_ce", 64'(srl_ce), 64'd0);
      chk("done_din", 64'(srl_din), 64'd0);
      chk("done_busy", 64'(busy), 64'd0);
      chk("done_ready", 64'(s_ready), 64'd1);
   endtask

   initial begin
      logic [DW-1:0] d, m;
      logic [AW-1:0] a;
      logic          c;

      // Reset state
      repeat (3) @(negedge clk);
      check_idle("reset");
      reset = 1'b0;
      @(negedge clk);
      check_idle("post_reset");

      // Exact match, addr 3
      xfer('0, '1, 3'd3, 1'b0);
      check_shift('0, '1, 3'd3, 1'b0, 32, 0);
      check_done();
      @(negedge clk);
      check_idle("after_done");

      // Partial mask on slice 0, other slices random
      d = DW'({$urandom, $urandom}); d[4:0] = 5'b10101;
      m = DW'({$urandom, $urandom}); m[4:0] = 5'b11110;
      xfer(d, m, 3'd5, 1'b0);
      check_shift(d, m, 3'd5, 1'b0, 32, 0);
      check_done();
      @(negedge clk);

      // Fully masked, then erase
      d = DW'({$urandom, $urandom});
      xfer(d, '0, 3'd0, 1'b0);
      check_shift(d, '0, 3'd0, 1'b0, 32, 0);
      check_done();
      @(negedge clk);
      xfer(d, '0, 3'd7, 1'b1);
      check_shift(d, '0, 3'd7, 1'b1, 32, 0);
      check_done();

      // Back-to-back: addr 1 then addr 6 transferred in DONE
      d = DW'({$urandom, $urandom}); m = DW'({$urandom, $urandom});
      xfer(d, m, 3'd1, 1'b0);
      check_shift(d, m, 3'd1, 1'b0, 32, 0);
      check_done();
      xfer(m, d, 3'd6, 1'b0);
      check_shift(m, d, 3'd6, 1'b0, 32, 0);
      check_done();
      @(negedge clk);

      // Reset during T+10: nothing shifts afterwards, no done pulse
      xfer(d, m, 3'd2, 1'b0);
      check_shift(d, m, 3'd2, 1'b0, 9, 0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 34; i++) begin
         check_idle("after_mid_reset");
         @(negedge clk);
      end
      xfer(m, d, 3'd4, 1'b0);
      check_shift(m, d, 3'd4, 1'b0, 32, 0);
      check_done();
      @(negedge clk);

`ifdef SRL_WR_QUEUE_EN
      // Queued second request presented at T+5
      q_data = DW'({$urandom, $urandom}); q_mask = DW'({$urandom, $urandom});
      q_addr = 3'd6; q_clear = 1'b0;
      xfer(d, m, 3'd1, 1'b0);
      check_shift(d, m, 3'd1, 1'b0, 32, 5);
      check_done();
      pend_exp = 1'b0;
      @(negedge clk);
      check_shift(q_data, q_mask, q_addr, q_clear, 32, 0);
      check_done();
      @(negedge clk);
`endif

      // Randomized requests with random idle gaps or back-to-back issue
      for (int r = 0; r < 8; r++) begin
         d = DW'({$urandom, $urandom});
         m = DW'({$urandom, $urandom});
         for (int j = 0; j < NS; j++) if ($urandom_range(3) == 0) m[5*j +: 5] = 5'd0;
         a = AW'($urandom);
         c = ($urandom_range(4) == 0);
         xfer(d, m, a, c);
         check_shift(d, m, a, c, 32, 0);
         check_done();
         if ($urandom_range(1) == 1) begin
            repeat ($urandom_range(3, 1)) begin
               @(negedge clk);
               check_idle("rand_gap");
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
